// File: rtl/mem_stage_pkg.sv
// Shared definitions for the out-of-order-completion memory stage:
// load-op encodings, entry state, and the load alignment/extension helper.
package mem_stage_pkg;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LB   = 3'd1;
   localparam logic [2:0] OP_LH   = 3'd2;
   localparam logic [2:0] OP_LW   = 3'd3;
   localparam logic [2:0] OP_LBU  = 3'd5;
   localparam logic [2:0] OP_LHU  = 3'd6;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2
   } entry_state_t;

   // True for the load kinds whose result comes from the SRAM read data.
   function automatic logic is_load(input logic [2:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   // Select the addressed byte/half of a read word and sign- or zero-extend it.
   // Halfword selection uses only the upper offset bit.
   function automatic logic [31:0] ld_extend(input logic [2:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
      logic [7:0]  sel_b;
      logic [15:0] sel_h;
      logic [31:0] res;
      sel_b = word[{off, 3'b000} +: 8];
      sel_h = off[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   res = {{24{sel_b[7]}}, sel_b};
         OP_LBU:  res = {24'h0, sel_b};
         OP_LH:   res = {{16{sel_h[15]}}, sel_h};
         OP_LHU:  res = {16'h0, sel_h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_stage_oq_load_align.sv
// Combinational byte/half select and extension on the SRAM read-data capture path.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] value,
   output logic        is_ld
);

   assign value = ld_extend(op, off, word);
   assign is_ld = is_load(op);

endmodule

// File: rtl/mem_stage_oq.sv
// Memory-access stage with a small in-order queue so up to DEPTH loads/stores
// can wait on data SRAM responses concurrently. Entries retire in program order;
// a flush converts every outstanding request into a "ghost" response to drop.
module mem_stage_oq
   import mem_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int BUS_W = 180
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_allow,
   input  logic [BUS_W-1:0]           in_payload,
   input  logic [31:0]                in_result,
   input  logic [2:0]                 in_ld_op,
   input  logic                       in_req,
   input  logic                       in_ex,
   input  logic                       data_ok,
   input  logic [31:0]                rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BUS_W-1:0]           out_payload,
   output logic [31:0]                out_result,
   output logic                       out_ex,
   input  logic                       flush,
   output logic [$clog2(DEPTH)+1:0]   pending,
   output logic                       proto_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = PW + 2;

   entry_state_t     state_q   [DEPTH];
   logic [BUS_W-1:0] payload_q [DEPTH];
   logic [31:0]      result_q  [DEPTH];
   logic [2:0]       ld_op_q   [DEPTH];
   logic             ex_q      [DEPTH];

   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic [NW-1:0] ghost_q;
   logic          proto_err_q;

   logic [NW-1:0] waiting;
   logic [PW-1:0] resp_ptr;
   logic          resp_found;
   logic          enq;
   logic          retire;
   logic          rsp_ghost;
   logic          rsp_hit;
   logic          rsp_err;
   logic [2:0]    cap_op;
   logic [1:0]    cap_off;
   logic [31:0]   aligned;
   logic          cap_is_ld;
   logic [31:0]   capture;

   // Acceptance depends only on registered occupancy; flush kills the enqueue.
   assign in_allow = (count_q < CW'(DEPTH));
   assign enq      = in_valid & in_allow & ~flush;

   // Head retires once complete; a flush in the same cycle suppresses it.
   assign out_valid   = (state_q[head_q] == DONE) & ~flush;
   assign retire      = out_valid & out_ready;
   assign out_payload = payload_q[head_q];
   assign out_result  = result_q[head_q];
   assign out_ex      = ex_q[head_q];

   // Count WAIT entries and locate the oldest one, which owns the next real response.
   // Entries that enqueued as DONE are passed over, so the response pointer skips them.
   always_comb begin
      waiting    = '0;
      resp_ptr   = head_q;
      resp_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (state_q[i] == WAIT) waiting = waiting + NW'(1);
         if (!resp_found && (state_q[head_q + PW'(i)] == WAIT)) begin
            resp_found = 1'b1;
            resp_ptr   = head_q + PW'(i);
         end
      end
   end

   assign pending   = ghost_q + waiting;
   assign proto_err = proto_err_q;

   // Ghosts are consumed strictly before responses to live entries.
   assign rsp_err   = data_ok & (pending == '0);
   assign rsp_ghost = data_ok & (ghost_q != '0);
   assign rsp_hit   = data_ok & (ghost_q == '0) & resp_found;

   assign cap_op  = ld_op_q[resp_ptr];
   assign cap_off = result_q[resp_ptr][1:0];

   load_align u_align (
      .op    (cap_op),
      .off   (cap_off),
      .word  (rdata),
      .value (aligned),
      .is_ld (cap_is_ld)
   );

   // Stores keep their address as the result; loads take the aligned read data.
   assign capture = cap_is_ld ? aligned : result_q[resp_ptr];

   // Control state: entry states, pointers, occupancy, ghost count and the sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) state_q[i] <= EMPTY;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ghost_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= EMPTY;
            head_q  <= tail_q;
            count_q <= '0;
            ghost_q <= ghost_q + waiting - NW'(data_ok & ~rsp_err);
         end else begin
            if (enq) begin
               state_q[tail_q] <= (in_req & ~in_ex) ? WAIT : DONE;
               tail_q          <= tail_q + PW'(1);
            end
            if (rsp_hit) state_q[resp_ptr] <= DONE;
            if (retire) begin
               state_q[head_q] <= EMPTY;
               head_q          <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(retire);
            if (rsp_ghost) ghost_q <= ghost_q - NW'(1);
         end
         if (rsp_err) proto_err_q <= 1'b1;
      end
   end

   // Entry data: written on enqueue, result overwritten when the owning response lands.
   always_ff @(posedge clk) begin
      if (enq) begin
         payload_q[tail_q] <= in_payload;
         result_q[tail_q]  <= in_result;
         ld_op_q[tail_q]   <= in_ld_op;
         ex_q[tail_q]      <= in_ex;
      end
      if (rsp_hit) result_q[resp_ptr] <= capture;
   end

endmodule

// File: tb/tb_mem_stage_oq.sv
// Self-checking bench for mem_stage_oq: directed scenarios plus a randomised
// overlap run, with a scoreboard of expected retirements checked by a monitor.
module tb_mem_stage_oq;
   import mem_stage_pkg::*;

   localparam int DEPTH = 2;
   localparam int BUS_W = 180;
   localparam int NW    = $clog2(DEPTH) + 2;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_allow;
   logic [BUS_W-1:0] in_payload;
   logic [31:0]      in_result;
   logic [2:0]       in_ld_op;
   logic             in_req;
   logic             in_ex;
   logic             data_ok;
   logic [31:0]      rdata;
   logic             out_valid;
   logic             out_ready;
   logic [BUS_W-1:0] out_payload;
   logic [31:0]      out_result;
   logic             out_ex;
   logic             flush;
   logic [NW-1:0]    pending;
   logic             proto_err;

   typedef struct {
      logic [31:0] result;
      logic        ex;
      logic [31:0] tag;
   } exp_t;

   exp_t        sb [$];
   int          checks_total  = 0;
   int          checks_passed = 0;
   logic [31:0] tag_ctr       = 0;
   logic [2:0]  op_tab [6];

   mem_stage_oq #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_allow    (in_allow),
      .in_payload  (in_payload),
      .in_result   (in_result),
      .in_ld_op    (in_ld_op),
      .in_req      (in_req),
      .in_ex       (in_ex),
      .data_ok     (data_ok),
      .rdata       (rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload),
      .out_result  (out_result),
      .out_ex      (out_ex),
      .flush       (flush),
      .pending     (pending),
      .proto_err   (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference load model: shift the word down by the byte offset, then extend.
   function automatic logic [31:0] tbExtend(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] data);
      logic [31:0] sh;
      sh = data >> {addr[1:0], 3'b000};
      case (op)
         3'd1:    return {{24{sh[7]}}, sh[7:0]};
         3'd5:    return {24'h0, sh[7:0]};
         3'd2:    return {{16{sh[15]}}, sh[15:0]};
         3'd6:    return {16'h0, sh[15:0]};
         3'd3:    return data;
         default: return addr;
      endcase
   endfunction

   function automatic logic [BUS_W-1:0] makePayload(input logic [31:0] tag);
      logic [BUS_W-1:0] p;
      p = '0;
      p[31:0] = tag;
      p[BUS_W-1 -: 32] = ~tag;
      return p;
   endfunction

   task automatic clearInputs();
      in_valid  = 1'b0;
      in_req    = 1'b0;
      in_ex     = 1'b0;
      in_ld_op  = 3'd0;
      in_result = 32'h0;
      data_ok   = 1'b0;
      rdata     = 32'h0;
      flush     = 1'b0;
   endtask

   // Advance one clock and return #1 after the edge with pulse inputs cleared.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   // Drive one cycle of response/flush activity.
   task automatic applyStimulus(input logic dok, input logic [31:0] rd, input logic fl);
      data_ok = dok;
      rdata   = rd;
      flush   = fl;
      stepCycle();
   endtask

   // Enqueue one entry; the expected retirement is computed from the planned read data.
   task automatic enqueueEntry(input logic [31:0] res, input logic [2:0] op, input logic req,
                               input logic ex, input logic [31:0] planned);
      exp_t e;
      checkOutput("enq_allow", {63'h0, in_allow}, 64'h1);
      tag_ctr++;
      e.tag    = tag_ctr;
      e.ex     = ex;
      e.result = (req && !ex) ? tbExtend(op, res, planned) : res;
      sb.push_back(e);
      in_valid   = 1'b1;
      in_result  = res;
      in_ld_op   = op;
      in_req     = req;
      in_ex      = ex;
      in_payload = makePayload(tag_ctr);
      stepCycle();
   endtask

   // Retirement monitor: sampled mid-cycle, pops the scoreboard on each handshake.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_retire", 64'h1, 64'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("ret_result", {32'h0, out_result}, {32'h0, e.result});
            checkOutput("ret_ex", {63'h0, out_ex}, {63'h0, e.ex});
            checkOutput("ret_payload", {out_payload[BUS_W-1 -: 32], out_payload[31:0]},
                        {~e.tag, e.tag});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rnd;
      logic [31:0] addr;
      logic [31:0] planned;
      logic [2:0]  op;
      logic        req;
      logic        ex;
      logic [31:0] rdq [$];
      int          items_left;
      int          guard;
      exp_t        e;

      op_tab[0] = OP_LB;  op_tab[1] = OP_LH;  op_tab[2] = OP_LW;
      op_tab[3] = OP_LBU; op_tab[4] = OP_LHU; op_tab[5] = OP_NONE;

      reset      = 1'b1;
      out_ready  = 1'b0;
      in_payload = '0;
      clearInputs();
      #2;
      checkOutput("rst_allow", {63'h0, in_allow}, 64'h1);
      checkOutput("rst_out_valid", {63'h0, out_valid}, 64'h0);
      checkOutput("rst_pending", {{(64-NW){1'b0}}, pending}, 64'h0);
      checkOutput("rst_proto_err", {63'h0, proto_err}, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Two loads completing in order with alignment and extension.
      $display("[TB] scenario: aligned loads");
      out_ready = 1'b1;
      enqueueEntry(32'h1000_0003, OP_LB,  1'b1, 1'b0, 32'h80FF_1234);
      enqueueEntry(32'h1000_0002, OP_LHU, 1'b1, 1'b0, 32'hABCD_0000);
      checkOutput("t1_pending", {{(64-NW){1'b0}}, pending}, 64'h2);
      checkOutput("t1_no_valid", {63'h0, out_valid}, 64'h0);
      applyStimulus(1'b1, 32'h80FF_1234, 1'b0);
      checkOutput("t1_valid_n1", {63'h0, out_valid}, 64'h1);
      checkOutput("t1_lb_result", {32'h0, out_result}, 64'hFFFF_FF80);
      applyStimulus(1'b1, 32'hABCD_0000, 1'b0);
      checkOutput("t1_lhu_result", {32'h0, out_result}, 64'h0000_ABCD);
      stepCycle();
      checkOutput("t1_drained", {63'h0, out_valid}, 64'h0);
      checkOutput("t1_sb_empty", 64'(sb.size()), 64'h0);

      // Exception entry waits behind an outstanding load.
      $display("[TB] scenario: exception behind load");
      enqueueEntry(32'h2000_0000, OP_LW, 1'b1, 1'b0, 32'h1111_2222);
      enqueueEntry(32'h01C0_0001, OP_LW, 1'b0, 1'b1, 32'h0);
      repeat (3) begin
         checkOutput("t2_blocked", {63'h0, out_valid}, 64'h0);
         stepCycle();
      end
      applyStimulus(1'b1, 32'h1111_2222, 1'b0);
      checkOutput("t2_load_first", {32'h0, out_result}, 64'h1111_2222);
      stepCycle();
      checkOutput("t2_ex_valid", {63'h0, out_valid}, 64'h1);
      checkOutput("t2_ex_flag", {63'h0, out_ex}, 64'h1);
      checkOutput("t2_ex_result", {32'h0, out_result}, 64'h01C0_0001);
      stepCycle();
      enqueueEntry(32'h2000_0010, OP_NONE, 1'b1, 1'b0, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
      stepCycle();
      checkOutput("t2_sb_empty", 64'(sb.size()), 64'h0);

      // Flush with two outstanding loads leaves two ghosts to drop.
      $display("[TB] scenario: flush ghosts");
      enqueueEntry(32'h3000_0000, OP_LW, 1'b1, 1'b0, 32'h0);
      enqueueEntry(32'h3000_0004, OP_LW, 1'b1, 1'b0, 32'h0);
      sb.delete();
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t3_pending", {{(64-NW){1'b0}}, pending}, 64'h2);
      checkOutput("t3_allow", {63'h0, in_allow}, 64'h1);
      enqueueEntry(32'h3000_0008, OP_LW, 1'b1, 1'b0, 32'h0000_0003);
      checkOutput("t3_pending3", {{(64-NW){1'b0}}, pending}, 64'h3);
      applyStimulus(1'b1, 32'h1, 1'b0);
      checkOutput("t3_ghost1_drop", {63'h0, out_valid}, 64'h0);
      applyStimulus(1'b1, 32'h2, 1'b0);
      checkOutput("t3_ghost2_drop", {63'h0, out_valid}, 64'h0);
      checkOutput("t3_pending1", {{(64-NW){1'b0}}, pending}, 64'h1);
      applyStimulus(1'b1, 32'h3, 1'b0);
      checkOutput("t3_live_result", {32'h0, out_result}, 64'h3);
      stepCycle();
      checkOutput("t3_sb_empty", 64'(sb.size()), 64'h0);

      // Flush coinciding with a response: one ghost remains.
      $display("[TB] scenario: flush with data_ok");
      enqueueEntry(32'h4000_0000, OP_LW, 1'b1, 1'b0, 32'h0);
      enqueueEntry(32'h4000_0004, OP_LW, 1'b1, 1'b0, 32'h0);
      sb.delete();
      applyStimulus(1'b1, 32'h5555_5555, 1'b1);
      checkOutput("t4_ghost1", {{(64-NW){1'b0}}, pending}, 64'h1);
      enqueueEntry(32'h4000_0008, OP_LW, 1'b1, 1'b0, 32'hCAFE_F00D);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
      checkOutput("t4_dropped", {63'h0, out_valid}, 64'h0);
      checkOutput("t4_pending", {{(64-NW){1'b0}}, pending}, 64'h1);
      applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0);
      checkOutput("t4_live", {32'h0, out_result}, 64'hCAFE_F00D);
      stepCycle();
      checkOutput("t4_proto_ok", {63'h0, proto_err}, 64'h0);
      checkOutput("t4_sb_empty", 64'(sb.size()), 64'h0);

      // Full queue with backpressure; in_allow must not follow out_ready combinationally.
      $display("[TB] scenario: full backpressure");
      out_ready = 1'b0;
      enqueueEntry(32'h5000_0001, OP_NONE, 1'b0, 1'b0, 32'h0);
      enqueueEntry(32'h5000_0002, OP_NONE, 1'b0, 1'b0, 32'h0);
      checkOutput("t5_full_allow", {63'h0, in_allow}, 64'h0);
      checkOutput("t5_head_valid", {63'h0, out_valid}, 64'h1);
      stepCycle();
      checkOutput("t5_still_full", {63'h0, in_allow}, 64'h0);
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_result  = 32'h5000_0003;
      in_ld_op   = OP_NONE;
      in_payload = makePayload(32'hFFFF_0000);
      #1;
      checkOutput("t5_allow_no_comb", {63'h0, in_allow}, 64'h0);
      stepCycle();
      checkOutput("t5_allow_rises", {63'h0, in_allow}, 64'h1);
      checkOutput("t5_second_valid", {32'h0, out_result}, 64'h5000_0002);
      stepCycle();
      checkOutput("t5_drained", {63'h0, out_valid}, 64'h0);
      checkOutput("t5_sb_empty", 64'(sb.size()), 64'h0);

      // Randomised overlap of enqueue, response and retire with random backpressure.
      $display("[TB] scenario: random overlap");
      items_left = 16;
      guard      = 0;
      while ((items_left > 0 || rdq.size() > 0) && guard < 400) begin
         guard++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (rdq.size() > 0 && $urandom_range(0, 1) == 1) begin
            data_ok = 1'b1;
            rdata   = rdq.pop_front();
         end
         if (items_left > 0) begin
            op      = op_tab[$urandom_range(0, 5)];
            rnd     = $urandom();
            planned = $urandom();
            ex      = ($urandom_range(0, 7) == 0);
            req     = !ex && ($urandom_range(0, 3) != 0);
            addr    = {rnd[31:2], 2'b00};
            if (op == OP_LB || op == OP_LBU) addr[1:0] = rnd[1:0];
            if (op == OP_LH || op == OP_LHU) addr[1] = rnd[1];
            in_valid   = 1'b1;
            in_result  = addr;
            in_ld_op   = op;
            in_req     = req;
            in_ex      = ex;
            in_payload = makePayload(tag_ctr + 32'd1);
            if (in_allow) begin
               tag_ctr++;
               e.tag    = tag_ctr;
               e.ex     = ex;
               e.result = req ? tbExtend(op, addr, planned) : addr;
               sb.push_back(e);
               if (req) rdq.push_back(planned);
               items_left--;
            end
         end
         stepCycle();
      end
      checkOutput("t7_bounded", {63'h0, guard < 400}, 64'h1);
      out_ready = 1'b1;
      repeat (6) stepCycle();
      checkOutput("t7_sb_empty", 64'(sb.size()), 64'h0);
      checkOutput("t7_pending", {{(64-NW){1'b0}}, pending}, 64'h0);
      checkOutput("t7_proto_ok", {63'h0, proto_err}, 64'h0);

      // Unowed response sets the sticky error; reset clears everything asynchronously.
      $display("[TB] scenario: protocol error and async reset");
      applyStimulus(1'b1, 32'h1234_5678, 1'b0);
      checkOutput("t6_proto_set", {63'h0, proto_err}, 64'h1);
      checkOutput("t6_no_valid", {63'h0, out_valid}, 64'h0);
      repeat (3) stepCycle();
      checkOutput("t6_proto_sticky", {63'h0, proto_err}, 64'h1);
      out_ready = 1'b0;
      enqueueEntry(32'h6000_0001, OP_NONE, 1'b0, 1'b0, 32'h0);
      enqueueEntry(32'h6000_0004, OP_LW, 1'b1, 1'b0, 32'h0);
      checkOutput("t6_pre_allow", {63'h0, in_allow}, 64'h0);
      checkOutput("t6_pre_pending", {{(64-NW){1'b0}}, pending}, 64'h1);
      checkOutput("t6_pre_valid", {63'h0, out_valid}, 64'h1);
      checkOutput("t6_pre_proto", {63'h0, proto_err}, 64'h1);
      #1;
      reset = 1'b1;
      sb.delete();
      #1;
      checkOutput("t6_rst_allow", {63'h0, in_allow}, 64'h1);
      checkOutput("t6_rst_valid", {63'h0, out_valid}, 64'h0);
      checkOutput("t6_rst_pending", {{(64-NW){1'b0}}, pending}, 64'h0);
      checkOutput("t6_rst_proto", {63'h0, proto_err}, 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      stepCycle();
      checkOutput("t6_post_valid", {63'h0, out_valid}, 64'h0);
      checkOutput("t6_post_proto", {63'h0, proto_err}, 64'h0);

      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
